lbus_arbiter: RTL and testbench
===============================

# lbus_arbiter

Two-master arbiter and sequencer for the 8-bit-address, 32-bit-data local register bus. The bus connects the configuration registers, clock generator, TDC channel block and histogram readout. Requester 0 is the slow-control bridge. Requester 1 is the internal channel-scan/histogram sequencer. The block serialises their accesses, drives the shared read/write strobes, captures the OR-combined read data, and returns it with a per-requester acknowledge.

## Interface
Parameters:
- ADDR_W, 8, local-bus address width
- DATA_W, 32, local-bus data width
- RD_LAT, 1, cycles from read-strobe assertion to read-data sample (legal 1..15)

Ports:
- clk  in  1  single clock for the whole block
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, held until matching ack
- we0 / we1  in  1  1 = write, 0 = read; valid while req high
- addr0 / addr1  in  ADDR_W  register address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata  out  DATA_W  captured read data, valid in ack cycle, held until next read completes
- busy  out  1  high in any state other than IDLE
- lb_addr  out  ADDR_W  local-bus address
- lb_read  out  1  local-bus read strobe
- lb_write  out  1  local-bus write strobe
- lb_dout  out  DATA_W  local-bus write data
- lb_din  in  DATA_W  OR-combined read data from all registers

## Operation
- FSM states: IDLE, STROBE, WAIT, DONE.
- IDLE: if any req is high, the block picks a winner and latches its we/addr/wdata. It records the winner in `last_grant`, then moves to STROBE.
- Arbitration: if only one req is high, that requester wins. If both are high, the requester not in `last_grant` wins (round-robin).
- STROBE, one cycle:
  - lb_addr = latched addr.
  - Write: lb_write=1, lb_dout=wdata, next state DONE.
  - Read: lb_read=1, next state WAIT; counter loaded with RD_LAT.
- WAIT: lb_read and lb_addr are held. The counter decrements each cycle. At the edge where the counter reaches 0, the block registers lb_din into rdata and moves to DONE.
- DONE, one cycle: the winner's ack is 1; next state IDLE. rdata changes only on reads.
- Requester rule: drop req in the ack cycle. A req still high at the next IDLE sample is a new access.
- Idle bus: when no access is in progress, lb_addr, lb_read, lb_write and lb_dout are all 0.
- Unmapped address: reads return 0, because lb_din is the OR of all sources. There is no error signal.
- Reset (async, any state): FSM goes to IDLE and every output is 0, including rdata. `last_grant` resets to 1, so requester 0 wins the first contention. An access in flight is abandoned with no ack and must be reissued.

## Timing
- Request sampled at edge E0 in IDLE; STROBE occupies [E0, E0+1).
- Write: lb_write high for exactly 1 cycle; ack high in [E0+1, E0+2). Access-to-access period is 3 cycles.
- Read: lb_read high for 1+RD_LAT cycles; lb_din sampled at edge E0+1+RD_LAT; ack high in [E0+1+RD_LAT, E0+2+RD_LAT).
- lb_addr is stable for the whole strobe interval.
- Back-to-back: IDLE always lasts at least 1 cycle between accesses. The pending requester is granted at the IDLE edge immediately after DONE.
- Maximum wait for a requester under continuous contention: one full access of the other requester.

## Configuration
- Macro: LBUS_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins simultaneous requests, `last_grant` is ignored, and requester 1 can be starved.
- Undefined (default): round-robin as above.

## Test plan
- Reset: rst_n low mid-read (state WAIT) -> all outputs 0 immediately; no ack; next access behaves normally.
- Single write: req0, we0=1, addr0=8'hC1, wdata0=32'h0000_0040 -> lb_write 1 cycle with lb_addr=C1 and lb_dout=0x40; ack0 one cycle later.
- Single read, RD_LAT=3: lb_din=32'h8000_0000 during the strobe, req1 read of addr 8'hC2 -> lb_read high 4 cycles; rdata=0x8000_0000 and ack1 at E0+4.
- Contention, default build: req0 and req1 both held for 4 accesses -> grant order 0,1,0,1 and each ack on the correct port.
- Contention with LBUS_ARB_FIXED_PRIO_EN: req0 held continuously plus req1 -> requester 0 gets every grant and ack1 never asserts.
- Unmapped read: addr 8'hFF with lb_din=0 -> rdata=0 and ack asserted; busy high from STROBE to DONE inclusive.

Source files
------------

// File: rtl/lbus_arbiter_if.sv
// Local register bus arbiter interface: both requester ports, the shared
// strobe bus and the returned read data.
// master modport: the arbiter side. slave modport: requesters plus the register fabric.
interface lbus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] lb_addr;
  logic              lb_read;
  logic              lb_write;
  logic [DATA_W-1:0] lb_dout;
  logic [DATA_W-1:0] lb_din;

  modport master (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lb_din,
    output ack0, ack1, rdata, busy, lb_addr, lb_read, lb_write, lb_dout
  );

  modport slave (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lb_din,
    input  ack0, ack1, rdata, busy, lb_addr, lb_read, lb_write, lb_dout
  );
endinterface

// File: rtl/lbus_arbiter.sv
// Two-master arbiter/sequencer for the local register bus.
// Requester 0: slow-control bridge; requester 1: channel-scan/histogram sequencer.
// Optional macro LBUS_ARB_FIXED_PRIO_EN: requester 0 always wins contention
// (default: round-robin on last_grant).
module lbus_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  lbus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              winner;

  // Pick the requester to serve when sampled in IDLE
  always_comb begin
    winner = 1'b0;
    if (bus.req0 && bus.req1) begin
`ifdef LBUS_ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last_grant_q;
`endif
    end else if (bus.req1) begin
      winner = 1'b1;
    end
  end

  // Next-state, access latching and read-data capture
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          last_grant_d = winner;
          we_d         = winner ? bus.we1    : bus.we0;
          addr_d       = winner ? bus.addr1  : bus.addr0;
          wdata_d      = winner ? bus.wdata1 : bus.wdata0;
          state_d      = STROBE;
        end
      end
      STROBE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = RD_LAT_C;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // counter holds the remaining read-strobe cycles; sample on the last one
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rdata_d = bus.lb_din;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  // Bus strobes and acknowledges decoded from the registered state
  always_comb begin
    bus.lb_addr  = '0;
    bus.lb_read  = 1'b0;
    bus.lb_write = 1'b0;
    bus.lb_dout  = '0;
    bus.ack0     = 1'b0;
    bus.ack1     = 1'b0;
    case (state_q)
      STROBE: begin
        bus.lb_addr  = addr_q;
        bus.lb_write = we_q;
        bus.lb_read  = ~we_q;
        if (we_q) begin
          bus.lb_dout = wdata_q;
        end
      end
      WAIT: begin
        bus.lb_addr = addr_q;
        bus.lb_read = 1'b1;
      end
      DONE: begin
        bus.ack0 = ~last_grant_q;
        bus.ack1 = last_grant_q;
      end
      default: begin
      end
    endcase
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_lbus_arbiter.sv
// Self-checking bench for lbus_arbiter (RD_LAT = 3).
module tb_lbus_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 3;
`ifdef LBUS_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef logic [76:0] obs_t;  // ack0,ack1,busy,lb_read,lb_write,lb_addr,lb_dout,rdata

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [DATA_W-1:0] exp_rdata = '0;
  logic lg = 1'b1;

  lbus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  lbus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic obs_t outs();
    return {bus.ack0, bus.ack1, bus.busy, bus.lb_read, bus.lb_write,
            bus.lb_addr, bus.lb_dout, bus.rdata};
  endfunction

  function automatic obs_t idle_obs(logic [DATA_W-1:0] rd);
    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, rd};
  endfunction

  function automatic obs_t wr_obs(logic [7:0] a, logic [DATA_W-1:0] d, logic [DATA_W-1:0] rd);
    return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, a, d, rd};
  endfunction

  function automatic obs_t rd_obs(logic [7:0] a, logic [DATA_W-1:0] rd);
    return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, a, 32'h0, rd};
  endfunction

  function automatic obs_t ack_obs(bit who, logic [DATA_W-1:0] rd);
    return {~who, who, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, rd};
  endfunction

  // spec arbitration rule: lone requester wins; contention goes to the one not granted last
  function automatic bit pick(bit r0, bit r1, bit last);
    if (r0 && r1) return FIXED ? 1'b0 : ~last;
    return r1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.lb_din = '0;
  endtask

  task automatic test_reset();
    obs_t o;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    o = outs();
    checks++;
    if (o !== idle_obs('0)) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", o, idle_obs('0));
    end
    rst_n = 1'b1;
    repeat (2) tick();
    o = outs();
    checks++;
    if (o !== idle_obs('0)) begin
      failures++; $display("FAIL reset_release_idle got=%h exp=%h", o, idle_obs('0));
    end
    exp_rdata = '0;
    lg = 1'b1;
  endtask

  task automatic test_single_write();
    obs_t o;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'hC1; bus.wdata0 = 32'h0000_0040;
    tick();
    o = outs(); checks++;
    if (o !== wr_obs(8'hC1, 32'h40, exp_rdata)) begin
      failures++; $display("FAIL write_strobe got=%h exp=%h", o, wr_obs(8'hC1, 32'h40, exp_rdata));
    end
    tick();
    o = outs(); checks++;
    if (o !== ack_obs(1'b0, exp_rdata)) begin
      failures++; $display("FAIL write_ack0 got=%h exp=%h", o, ack_obs(1'b0, exp_rdata));
    end
    bus.req0 = 1'b0;
    tick();
    o = outs(); checks++;
    if (o !== idle_obs(exp_rdata)) begin
      failures++; $display("FAIL write_idle got=%h exp=%h", o, idle_obs(exp_rdata));
    end
    lg = 1'b0;
  endtask

  task automatic test_unmapped_read();
    obs_t o;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'hFF; bus.wdata0 = 32'hDEAD_BEEF;
    bus.lb_din = '0;
    for (int j = 0; j <= RD_LAT; j++) begin
      tick();
      o = outs(); checks++;
      if (o !== rd_obs(8'hFF, exp_rdata)) begin
        failures++; $display("FAIL unmapped_strobe j=%0d got=%h exp=%h", j, o, rd_obs(8'hFF, exp_rdata));
      end
    end
    tick();
    exp_rdata = '0;
    o = outs(); checks++;
    if (o !== ack_obs(1'b0, exp_rdata)) begin
      failures++; $display("FAIL unmapped_ack got=%h exp=%h", o, ack_obs(1'b0, exp_rdata));
    end
    bus.req0 = 1'b0;
    tick();
    o = outs(); checks++;
    if (o !== idle_obs(exp_rdata)) begin
      failures++; $display("FAIL unmapped_idle got=%h exp=%h", o, idle_obs(exp_rdata));
    end
    lg = 1'b0;
  endtask

  task automatic test_single_read();
    obs_t o;
    bus.lb_din = 32'h8000_0000;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'hC2; bus.wdata1 = 32'h1234_5678;
    for (int j = 0; j <= RD_LAT; j++) begin
      tick();
      o = outs(); checks++;
      if (o !== rd_obs(8'hC2, exp_rdata)) begin
        failures++; $display("FAIL read_strobe j=%0d got=%h exp=%h", j, o, rd_obs(8'hC2, exp_rdata));
      end
    end
    tick();
    exp_rdata = 32'h8000_0000;
    o = outs(); checks++;
    if (o !== ack_obs(1'b1, exp_rdata)) begin
      failures++; $display("FAIL read_ack1 got=%h exp=%h", o, ack_obs(1'b1, exp_rdata));
    end
    bus.req1 = 1'b0;
    bus.lb_din = '0;
    tick();
    o = outs(); checks++;
    if (o !== idle_obs(exp_rdata)) begin
      failures++; $display("FAIL read_idle_hold got=%h exp=%h", o, idle_obs(exp_rdata));
    end
    lg = 1'b1;
  endtask

  task automatic test_reset_midread();
    obs_t o;
    bus.lb_din = 32'hA5A5_0000;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h33;
    tick();
    tick();
    o = outs(); checks++;
    if (o !== rd_obs(8'h33, exp_rdata)) begin
      failures++; $display("FAIL midread_wait got=%h exp=%h", o, rd_obs(8'h33, exp_rdata));
    end
    #2 rst_n = 1'b0;
    #1;
    exp_rdata = '0;
    o = outs(); checks++;
    if (o !== idle_obs('0)) begin
      failures++; $display("FAIL midread_async_reset got=%h exp=%h", o, idle_obs('0));
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      o = outs(); checks++;
      if (o !== idle_obs('0)) begin
        failures++; $display("FAIL midread_no_ack j=%0d got=%h exp=%h", j, o, idle_obs('0));
      end
    end
    // first contention after reset goes to requester 0, then requester 1
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'hA0; bus.wdata0 = 32'h0000_00D1;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'hB0; bus.wdata1 = 32'h0000_00D2;
    tick();
    o = outs(); checks++;
    if (o !== wr_obs(8'hA0, 32'hD1, '0)) begin
      failures++; $display("FAIL post_reset_first_grant got=%h exp=%h", o, wr_obs(8'hA0, 32'hD1, '0));
    end
    tick();
    o = outs(); checks++;
    if (o !== ack_obs(1'b0, '0)) begin
      failures++; $display("FAIL post_reset_ack0 got=%h exp=%h", o, ack_obs(1'b0, '0));
    end
    bus.req0 = 1'b0;
    tick();
    o = outs(); checks++;
    if (o !== idle_obs('0)) begin
      failures++; $display("FAIL post_reset_gap got=%h exp=%h", o, idle_obs('0));
    end
    tick();
    o = outs(); checks++;
    if (o !== wr_obs(8'hB0, 32'hD2, '0)) begin
      failures++; $display("FAIL post_reset_second_grant got=%h exp=%h", o, wr_obs(8'hB0, 32'hD2, '0));
    end
    tick();
    o = outs(); checks++;
    if (o !== ack_obs(1'b1, '0)) begin
      failures++; $display("FAIL post_reset_ack1 got=%h exp=%h", o, ack_obs(1'b1, '0));
    end
    bus.req1 = 1'b0;
    tick();
    lg = 1'b1;
  endtask

  task automatic test_contention();
    obs_t o;
    bit w;
    int ack1_seen;
    logic [7:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;
    ack1_seen = 0;
    a0 = 8'h10; a1 = 8'h20; d0 = 32'h100; d1 = 32'h200;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = a1; bus.wdata1 = d1;
    for (int k = 0; k < 4; k++) begin
      w = pick(1'b1, 1'b1, lg);
      lg = w;
      tick();
      o = outs(); checks++;
      if (o !== wr_obs(w ? a1 : a0, w ? d1 : d0, exp_rdata)) begin
        failures++;
        $display("FAIL contention_grant k=%0d got=%h exp=%h", k, o, wr_obs(w ? a1 : a0, w ? d1 : d0, exp_rdata));
      end
      tick();
      if (bus.ack1) ack1_seen++;
      o = outs(); checks++;
      if (o !== ack_obs(w, exp_rdata)) begin
        failures++; $display("FAIL contention_ack k=%0d got=%h exp=%h", k, o, ack_obs(w, exp_rdata));
      end
      if (w) bus.req1 = 1'b0; else bus.req0 = 1'b0;
      tick();
      if (w) begin
        a1 = a1 + 8'd1; d1 = d1 + 32'd1;
        bus.req1 = 1'b1; bus.addr1 = a1; bus.wdata1 = d1;
      end else begin
        a0 = a0 + 8'd1; d0 = d0 + 32'd1;
        bus.req0 = 1'b1; bus.addr0 = a0; bus.wdata0 = d0;
      end
    end
    checks++;
    if (FIXED && ack1_seen != 0) begin
      failures++; $display("FAIL fixed_prio_ack1 got=%0d exp=0", ack1_seen);
    end else if (!FIXED && ack1_seen != 2) begin
      failures++; $display("FAIL rr_ack1_count got=%0d exp=2", ack1_seen);
    end
    // the grant issued at the last re-raise edge still has to drain
    w = pick(1'b1, 1'b1, lg);
    lg = w;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    if (w) bus.req1 = 1'b1; else bus.req0 = 1'b1;
    tick();
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random(int ncyc);
    obs_t o, e;
    int j, len;
    bit cw, cwe;
    logic [7:0] caddr;
    logic [DATA_W-1:0] cwdata, pend;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    lg = 1'b1; exp_rdata = '0;
    j = -1; len = 0; cw = 1'b0; cwe = 1'b0; caddr = '0; cwdata = '0; pend = '0;
    tick();
    for (int c = 0; c < ncyc; c++) begin
      if (j < 0) e = idle_obs(exp_rdata);
      else if (j == len - 1) begin
        if (!cwe) exp_rdata = pend;
        e = ack_obs(cw, exp_rdata);
      end else if (cwe) e = wr_obs(caddr, cwdata, exp_rdata);
      else e = rd_obs(caddr, exp_rdata);
      o = outs(); checks++;
      if (o !== e) begin
        failures++; $display("FAIL random c=%0d got=%h exp=%h", c, o, e);
      end
      // requesters: drop on ack, otherwise maybe raise a new access
      if (j >= 0 && j == len - 1 && !cw) bus.req0 = 1'b0;
      else if (!bus.req0 && $urandom_range(99) < 40) begin
        bus.req0 = 1'b1; bus.we0 = 1'($urandom); bus.addr0 = 8'($urandom); bus.wdata0 = $urandom;
      end
      if (j >= 0 && j == len - 1 && cw) bus.req1 = 1'b0;
      else if (!bus.req1 && $urandom_range(99) < 40) begin
        bus.req1 = 1'b1; bus.we1 = 1'($urandom); bus.addr1 = 8'($urandom); bus.wdata1 = $urandom;
      end
      bus.lb_din = $urandom;
      if (j >= 0 && !cwe && j == len - 2) pend = bus.lb_din;
      if (j >= 0 && j == len - 1) j = -1;
      else if (j >= 0) j++;
      else if (bus.req0 || bus.req1) begin
        cw = pick(bus.req0, bus.req1, lg);
        lg = cw;
        cwe = cw ? bus.we1 : bus.we0;
        caddr = cw ? bus.addr1 : bus.addr0;
        cwdata = cw ? bus.wdata1 : bus.wdata0;
        len = cwe ? 2 : RD_LAT + 2;
        j = 0;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_unmapped_read();
    test_single_read();
    test_reset_midread();
    test_contention();
    test_random(600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
